// File: rtl/axis_downsizer.sv
// axis_downsizer
//
// Serializes one wide AXI-stream word (K lanes of N bits) into K narrow
// beats on a narrow AXI-stream master. On the final wide word of a packet
// the lane count s_cnt trims the trailing unused lanes. Back-to-back wide
// words are serialized with no idle cycle between them.
//
// Configuration macro:
//   AXIS_DOWNSIZER_MSB_FIRST_EN  when defined, lanes are emitted from lane
//                                K-1 downwards; otherwise from lane 0 upwards.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   s_data   in   wide word, lane i = s_data[N*i +: N]
//   s_cnt    in   index of last valid lane (used only with s_last)
//   s_last   in   final wide word of a packet
//   s_valid  in   slave valid
//   s_ready  out  slave ready (combinational from m_ready)
//   m_data   out  narrow beat
//   m_last   out  final narrow beat of a packet
//   m_valid  out  master valid
//   m_ready  in   master ready

module axis_downsizer #(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N*K-1:0]        s_data,
   input  logic [$clog2(K)-1:0]  s_cnt,
   input  logic                  s_last,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [N-1:0]          m_data,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready
);

   localparam int CW = $clog2(K);
   localparam logic [CW-1:0] LAST_LANE = CW'(K - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);

`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
   localparam int FIRST_IDX = K - 1;
`else
   localparam int FIRST_IDX = 0;
`endif

   localparam logic [CW-1:0] FIRST_LANE = CW'(FIRST_IDX);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t          state;
   logic [N*K-1:0]  held_data;
   logic            held_last;
   logic [CW-1:0]   lim;
   logic [CW-1:0]   idx;
   logic [CW-1:0]   idx_nxt;
   logic [CW-1:0]   final_lane;
   logic [CW-1:0]   new_lim;
   logic            idx_final;
   logic            accept;
   logic            load_last;
   logic [N-1:0]    first_data;
   logic [N-1:0]    next_data;

   // Lane order: the final lane is derived from the held limit, and the
   // counter steps towards it one lane per handshake.
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
   assign final_lane = LAST_LANE - lim;
   assign idx_nxt    = idx - ONE;
`else
   assign final_lane = lim;
   assign idx_nxt    = idx + ONE;
`endif

   assign idx_final = (idx == final_lane);

   // s_ready is combinational from m_ready so the next wide word can be
   // taken on the same cycle the last narrow beat leaves, avoiding a bubble.
   // Register-slice downstream if this path limits timing.
   assign s_ready = ~reset & ((state == IDLE) | (m_ready & idx_final));
   assign accept  = s_valid & s_ready;

   // A freshly loaded word whose limit is zero is a single-beat packet end,
   // in either lane order, because the first lane is then also the final one.
   assign new_lim   = s_last ? s_cnt : LAST_LANE;
   assign load_last = s_last & (new_lim == '0);

   // Lane muxes: the first lane of an incoming word and the next lane of the
   // held word, so m_data can be driven from a register.
   always_comb begin
      first_data = s_data[N*FIRST_IDX +: N];
      next_data  = '0;
      for (int i = 0; i < K; i++) begin
         if (idx_nxt == CW'(i)) begin
            next_data = held_data[N*i +: N];
         end
      end
   end

   // Control FSM with registered outputs. The holding register is only
   // loaded in IDLE or on the final-beat handshake, never mid-word, and the
   // outputs are frozen whenever m_ready is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_data    <= '0;
         idx       <= '0;
         lim       <= '0;
         held_data <= '0;
         held_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  held_data <= s_data;
                  held_last <= s_last;
                  lim       <= new_lim;
                  idx       <= FIRST_LANE;
                  m_data    <= first_data;
                  m_last    <= load_last;
                  m_valid   <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (m_ready) begin
                  if (!idx_final) begin
                     idx    <= idx_nxt;
                     m_data <= next_data;
                     m_last <= held_last & (idx_nxt == final_lane);
                  end else if (s_valid) begin
                     held_data <= s_data;
                     held_last <= s_last;
                     lim       <= new_lim;
                     idx       <= FIRST_LANE;
                     m_data    <= first_data;
                     m_last    <= load_last;
                  end else begin
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_downsizer.sv
// tb_axis_downsizer
//
// Self-checking bench for axis_downsizer (N=8, K=4). A queue-based reference
// model turns every accepted wide word into its list of expected narrow
// beats; outputs are compared against the head of that queue each cycle.
// Honours AXIS_DOWNSIZER_MSB_FIRST_EN for lane order.

module tb_axis_downsizer;

   localparam int N = 8;
   localparam int K = 4;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic        clk;
   logic        reset;
   logic [31:0] s_data;
   logic [1:0]  s_cnt;
   logic        s_last;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  m_data;
   logic        m_last;
   logic        m_valid;
   logic        m_ready;

   beat_t expq[$];
   int    total;
   int    bad;

   axis_downsizer #(
      .N(N),
      .K(K)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .s_data  (s_data),
      .s_cnt   (s_cnt),
      .s_last  (s_last),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .m_valid (m_valid),
      .m_ready (m_ready)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports each check.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expand a wide word into its narrow beats in emit order.
   task automatic pushWord(input logic [31:0] d, input logic l, input logic [1:0] c);
      int    n;
      int    lane;
      beat_t b;
      n = l ? int'(c) + 1 : K;
      for (int i = 0; i < n; i++) begin
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
         lane = K - 1 - i;
`else
         lane = i;
`endif
         b.d = 8'((d >> (8 * lane)) & 32'hFF);
         b.l = l && (i == n - 1);
         expq.push_back(b);
      end
   endtask

   // One clock cycle: drive inputs, check s_ready, advance the model on the
   // edge, then check the presented beat against the head of the queue.
   task automatic applyStimulus(input logic rst, input logic sv, input logic [31:0] d,
                                input logic l, input logic [1:0] c, input logic mr,
                                output logic acc);
      logic exp_rdy;
      reset   = rst;
      s_valid = sv;
      s_data  = d;
      s_last  = l;
      s_cnt   = c;
      m_ready = mr;
      #1;
      exp_rdy = !rst && (expq.size() == 0 || (mr && expq.size() == 1));
      checkOutput("s_ready", 32'(s_ready), 32'(exp_rdy));
      acc = sv && exp_rdy;
      @(posedge clk);
      if (rst) begin
         expq.delete();
      end else begin
         if (mr && expq.size() > 0) void'(expq.pop_front());
         if (acc) pushWord(d, l, c);
      end
      @(negedge clk);
      checkOutput("m_valid", 32'(m_valid), 32'(expq.size() > 0));
      if (expq.size() > 0) begin
         checkOutput("m_data", 32'(m_data), 32'(expq[0].d));
         checkOutput("m_last", 32'(m_last), 32'(expq[0].l));
      end
   endtask

   // Run with m_ready high and no new input until the model is empty.
   task automatic drain();
      logic acc;
      for (int i = 0; i < 2 * K + 2 && expq.size() > 0; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
      end
      checkOutput("drain", 32'(expq.size()), 32'd0);
   endtask

   logic [31:0] words [3];
   logic        acc;
   int          w;
   logic        bp [4];

   initial begin
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      s_cnt   = '0;
      m_ready = 1'b0;
      @(negedge clk);

      // Reset state.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, 32'h12345678, 1'b0, 2'd0, 1'b1, acc);
      checkOutput("rst_m_data", 32'(m_data), 32'd0);
      checkOutput("rst_m_last", 32'(m_last), 32'd0);

      // Single full word.
      applyStimulus(1'b0, 1'b1, 32'h44332211, 1'b0, 2'd3, 1'b1, acc);
      checkOutput("single_first", 32'(m_data),
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
                  32'h44);
`else
                  32'h11);
`endif
      drain();

      // Trimmed last word.
      applyStimulus(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1, 2'd1, 1'b1, acc);
      drain();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, acc);

      // Single-beat last word.
      applyStimulus(1'b0, 1'b1, 32'h55667788, 1'b1, 2'd0, 1'b1, acc);
      drain();

      // Back-to-back words with s_valid held high.
      words[0] = 32'hA3A2A1A0;
      words[1] = 32'hB3B2B1B0;
      words[2] = 32'hC3C2C1C0;
      w = 0;
      for (int i = 0; i < 16 && w < 3; i++) begin
         applyStimulus(1'b0, 1'b1, words[w], 1'b0, 2'd0, 1'b1, acc);
         if (acc) w++;
      end
      checkOutput("b2b_accepted", 32'(w), 32'd3);
      drain();

      // Backpressure in mid-word.
      bp[0] = 1'b1; bp[1] = 1'b0; bp[2] = 1'b0; bp[3] = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h0D0C0B0A, 1'b1, 2'd3, 1'b1, acc);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 32'hEEEEEEEE, 1'b0, 2'd0, bp[i], acc);
      end
      drain();

      // Reset in mid-word, then a fresh word.
      applyStimulus(1'b0, 1'b1, 32'hF3F2F1F0, 1'b0, 2'd0, 1'b1, acc);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, acc);
      checkOutput("rst_mid_valid", 32'(m_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h04030201, 1'b0, 2'd0, 1'b1, acc);
      drain();

      // MSB-first directed word (LSB-first order in the default build).
      applyStimulus(1'b0, 1'b1, 32'h44332211, 1'b1, 2'd2, 1'b1, acc);
      drain();

      // Randomized traffic with backpressure and occasional reset.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(99) == 0) ? 1'b1 : 1'b0,
                       1'($urandom_range(1)),
                       32'($urandom),
                       1'($urandom_range(1)),
                       2'($urandom_range(3)),
                       ($urandom_range(9) < 7) ? 1'b1 : 1'b0,
                       acc);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
